// File: rtl/resize_update_scheduler_if.sv
// Bundle of request, acknowledge and coefficient-update signals around
// resize_update_scheduler.
//   slave  : the scheduler (consumes requests and vsync, drives acks, update and box)
//   master : the requesters / environment (drive requests and vsync)
// Box words are packed {y2, x2, y1, x1}, 16 bits each.
interface resize_update_scheduler_if;
    logic        sw_req;
    logic [63:0] sw_box;
    logic        sw_ack;
    logic        trk_req;
    logic [63:0] trk_box;
    logic        trk_ack;
    logic [1:0]  status;
    logic        vsync;
    logic        update;
    logic [15:0] top_left_x;
    logic [15:0] top_left_y;
    logic [15:0] bot_right_x;
    logic [15:0] bot_right_y;
    logic        busy;
    logic        last_src;
    logic [15:0] applied_count;

    modport slave (
        input  sw_req, sw_box, trk_req, trk_box, vsync,
        output sw_ack, trk_ack, status, update,
        output top_left_x, top_left_y, bot_right_x, bot_right_y,
        output busy, last_src, applied_count
    );

    modport master (
        output sw_req, sw_box, trk_req, trk_box, vsync,
        input  sw_ack, trk_ack, status, update,
        input  top_left_x, top_left_y, bot_right_x, bot_right_y,
        input  busy, last_src, applied_count
    );
endinterface

// File: rtl/resize_update_scheduler.sv
// Arbitrates bounding-box updates from software (sw) and the cluster tracker (trk)
// onto the single update port of the resize coefficient unit. A granted box is
// range-checked, issued as a one-cycle update pulse with a stable box, and the
// requester is acknowledged once the new coefficients were applied at a vsync
// rising edge (or on an invalid box / vsync timeout).
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : request/ack/status, vsync, update pulse, box outputs, busy,
//            last_src and applied_count (see resize_update_scheduler_if)
module resize_update_scheduler #(
    parameter int unsigned FRAME_W     = 640,
    parameter int unsigned FRAME_H     = 480,
    parameter int unsigned BUSY_CYCLES = 32,      // must be >= 28
    parameter int unsigned VS_TIMEOUT  = 4194304
) (
    input logic                       clk,
    input logic                       resetn,
    resize_update_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StBusy,
        StWaitVs,
        StDone
    } state_e;

    localparam logic [1:0]  StatusOk      = 2'b00;
    localparam logic [1:0]  StatusInvalid = 2'b01;
    localparam logic [1:0]  StatusTimeout = 2'b10;

    localparam logic [16:0] FrameW   = 17'(FRAME_W);
    localparam logic [16:0] FrameH   = 17'(FRAME_H);
    localparam logic [16:0] MaxSpan  = 17'd4095;
    localparam logic [31:0] BusyLast = 32'(BUSY_CYCLES - 1);
    localparam logic [31:0] VsLast   = 32'(VS_TIMEOUT - 1);

    // Matches the coefficient unit's reset coefficients: {y2, x2, y1, x1}.
    localparam logic [63:0] BoxReset = {16'd100, 16'd100, 16'd10, 16'd10};

    state_e      state_q, state_d;
    logic        src_q, src_d;            // source of the grant in flight
    logic [63:0] cap_q, cap_d;            // box captured at grant
    logic [63:0] box_q, box_d;            // box presented to the coefficient unit
    logic [31:0] cnt_q, cnt_d;            // shared BUSY / WAIT_VS cycle counter
    logic [1:0]  status_q, status_d;
    logic        last_src_q, last_src_d;
    logic [15:0] applied_q, applied_d;
    logic        vsync_q;
    logic        sw_blk_q, trk_blk_q;     // req-drop cycle after own ack

    logic        sw_ack_w, trk_ack_w;
    logic        sw_elig, trk_elig, grant_src;
    logic        vs_rise;
    logic [15:0] x1, y1, x2, y2;
    logic [16:0] span_w, span_h;
    logic        box_bad;

    assign sw_elig  = bus.sw_req  & ~sw_blk_q;
    assign trk_elig = bus.trk_req & ~trk_blk_q;
    // On a tie the winner is the source that did not win last time.
    assign grant_src = (sw_elig && trk_elig) ? ~last_src_q : trk_elig;

    assign vs_rise = bus.vsync & ~vsync_q;

    assign x1 = cap_q[15:0];
    assign y1 = cap_q[31:16];
    assign x2 = cap_q[47:32];
    assign y2 = cap_q[63:48];

    // 17-bit spans; only meaningful when the ordering terms below are clear.
    assign span_w = {1'b0, x2} - {1'b0, x1} + 17'd1;
    assign span_h = {1'b0, y2} - {1'b0, y1} + 17'd1;

    assign box_bad = (x2 < x1) || (y2 < y1) ||
                     ({1'b0, x2} >= FrameW) || ({1'b0, y2} >= FrameH) ||
                     (span_w > MaxSpan) || (span_h > MaxSpan);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cap_d      = cap_q;
        box_d      = box_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        last_src_d = last_src_q;
        applied_d  = applied_q;

        unique case (state_q)
            StIdle: begin
                if (sw_elig || trk_elig) begin
                    src_d      = grant_src;
                    last_src_d = grant_src;
                    cap_d      = grant_src ? bus.trk_box : bus.sw_box;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (box_bad) begin
                    status_d = StatusInvalid;
                    state_d  = StDone;
                end else begin
                    box_d   = cap_q;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                // vsync edges here are ignored; coefficients are still being computed.
                if (cnt_q == BusyLast) begin
                    cnt_d   = '0;
                    state_d = StWaitVs;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitVs: begin
                if (vs_rise) begin
                    status_d  = StatusOk;
                    applied_d = applied_q + 16'd1;
                    state_d   = StDone;
                end else if (cnt_q == VsLast) begin
                    status_d = StatusTimeout;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                last_src_d = src_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            src_q      <= 1'b0;
            cap_q      <= '0;
            box_q      <= BoxReset;
            cnt_q      <= '0;
            status_q   <= StatusOk;
            last_src_q <= 1'b1;
            applied_q  <= '0;
            vsync_q    <= 1'b0;
            sw_blk_q   <= 1'b0;
            trk_blk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cap_q      <= cap_d;
            box_q      <= box_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            last_src_q <= last_src_d;
            applied_q  <= applied_d;
            vsync_q    <= bus.vsync;
            sw_blk_q   <= sw_ack_w;
            trk_blk_q  <= trk_ack_w;
        end
    end

    assign sw_ack_w  = (state_q == StDone) && !src_q;
    assign trk_ack_w = (state_q == StDone) &&  src_q;

    assign bus.sw_ack        = sw_ack_w;
    assign bus.trk_ack       = trk_ack_w;
    assign bus.status        = status_q;
    assign bus.update        = (state_q == StIssue);
    assign bus.top_left_x    = box_q[15:0];
    assign bus.top_left_y    = box_q[31:16];
    assign bus.bot_right_x   = box_q[47:32];
    assign bus.bot_right_y   = box_q[63:48];
    assign bus.busy          = (state_q != StIdle);
    assign bus.last_src      = last_src_q;
    assign bus.applied_count = applied_q;

endmodule

// File: tb/tb_resize_update_scheduler.sv
module tb_resize_update_scheduler;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    resize_update_scheduler_if bus0 ();
    resize_update_scheduler_if bus1 ();

    resize_update_scheduler u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0.slave)
    );

    // Short vsync timeout instance for the timeout case.
    resize_update_scheduler #(
        .VS_TIMEOUT (200)
    ) u_dut_to (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic check_box0(input string tag, input logic [15:0] x1, input logic [15:0] y1,
                              input logic [15:0] x2, input logic [15:0] y2);
        check_eq({tag, "_x1"}, bus0.top_left_x, x1);
        check_eq({tag, "_y1"}, bus0.top_left_y, y1);
        check_eq({tag, "_x2"}, bus0.bot_right_x, x2);
        check_eq({tag, "_y2"}, bus0.bot_right_y, y2);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int cyc;
        bit got;

        bus0.sw_req = 0; bus0.sw_box = '0; bus0.trk_req = 0; bus0.trk_box = '0; bus0.vsync = 0;
        bus1.sw_req = 0; bus1.sw_box = '0; bus1.trk_req = 0; bus1.trk_box = '0; bus1.vsync = 0;

        // Reset values
        do_reset();
        check_eq("rst_busy", bus0.busy, 0);
        check_eq("rst_update", bus0.update, 0);
        check_eq("rst_sw_ack", bus0.sw_ack, 0);
        check_eq("rst_trk_ack", bus0.trk_ack, 0);
        check_eq("rst_status", bus0.status, 0);
        check_eq("rst_applied", bus0.applied_count, 0);
        check_eq("rst_last_src", bus0.last_src, 1);
        check_box0("rst_box", 16'd10, 16'd10, 16'd100, 16'd100);

        // Single sw request (20,30)-(119,129), vsync 100 cycles after update
        bus0.sw_box = {16'd129, 16'd119, 16'd30, 16'd20};
        bus0.sw_req = 1;
        step(1);
        check_eq("t1_busy", bus0.busy, 1);
        check_eq("t1_upd_early", bus0.update, 0);
        check_eq("t1_last_src", bus0.last_src, 0);
        step(1);
        check_eq("t1_update", bus0.update, 1);
        check_box0("t1_box", 16'd20, 16'd30, 16'd119, 16'd129);
        step(1);
        check_eq("t1_upd_pulse", bus0.update, 0);
        step(99);
        bus0.vsync = 1;
        step(1);
        check_eq("t1_sw_ack", bus0.sw_ack, 1);
        check_eq("t1_trk_ack", bus0.trk_ack, 0);
        check_eq("t1_status", bus0.status, 0);
        check_eq("t1_applied", bus0.applied_count, 1);
        bus0.sw_req = 0;
        bus0.vsync = 0;
        step(1);
        check_eq("t1_idle", bus0.busy, 0);
        check_eq("t1_ack_pulse", bus0.sw_ack, 0);

        // Tie after reset: sw first, then trk
        do_reset();
        bus0.sw_box  = {16'd129, 16'd119, 16'd30, 16'd20};
        bus0.trk_box = {16'd200, 16'd300, 16'd40, 16'd50};
        bus0.sw_req  = 1;
        bus0.trk_req = 1;
        step(1);
        check_eq("t2_busy", bus0.busy, 1);
        check_eq("t2_sw_won", bus0.last_src, 0);
        step(40);
        bus0.vsync = 1;
        step(1);
        check_eq("t2_sw_ack", bus0.sw_ack, 1);
        check_eq("t2_no_trk_ack", bus0.trk_ack, 0);
        bus0.sw_req = 0;
        bus0.vsync = 0;
        step(1);
        check_eq("t2_drop_idle", bus0.busy, 0);
        step(1);
        check_eq("t2_trk_busy", bus0.busy, 1);
        check_eq("t2_trk_won", bus0.last_src, 1);
        step(40);
        bus0.vsync = 1;
        step(1);
        check_eq("t2_trk_ack", bus0.trk_ack, 1);
        check_eq("t2_no_sw_ack", bus0.sw_ack, 0);
        check_eq("t2_last_src", bus0.last_src, 1);
        check_eq("t2_status", bus0.status, 0);
        check_eq("t2_applied", bus0.applied_count, 2);
        bus0.trk_req = 0;
        bus0.vsync = 0;

        // Invalid boxes from trk: x2 < x1, then x2 == FRAME_W
        step(2);
        bus0.trk_box = {16'd100, 16'd5, 16'd20, 16'd10};
        bus0.trk_req = 1;
        step(1);
        check_eq("t3a_busy", bus0.busy, 1);
        check_eq("t3a_no_upd1", bus0.update, 0);
        step(1);
        check_eq("t3a_trk_ack", bus0.trk_ack, 1);
        check_eq("t3a_status", bus0.status, 1);
        check_eq("t3a_no_upd2", bus0.update, 0);
        check_box0("t3a_box", 16'd50, 16'd40, 16'd300, 16'd200);
        bus0.trk_req = 0;
        step(2);
        bus0.trk_box = {16'd100, 16'd640, 16'd20, 16'd10};
        bus0.trk_req = 1;
        step(1);
        check_eq("t3b_no_upd", bus0.update, 0);
        step(1);
        check_eq("t3b_trk_ack", bus0.trk_ack, 1);
        check_eq("t3b_status", bus0.status, 1);
        check_eq("t3b_applied", bus0.applied_count, 2);
        bus0.trk_req = 0;

        // Full-frame box; vsync inside BUSY ignored, ack on the later edge
        step(2);
        bus0.sw_box = {16'd479, 16'd639, 16'd0, 16'd0};
        bus0.sw_req = 1;
        step(2);
        check_eq("t4_update", bus0.update, 1);
        check_box0("t4_box", 16'd0, 16'd0, 16'd639, 16'd479);
        step(10);
        bus0.vsync = 1;
        step(1);
        bus0.vsync = 0;
        acks = 0;
        for (int i = 0; i < 999; i++) begin
            step(1);
            if (bus0.sw_ack || bus0.trk_ack) acks++;
        end
        check_eq("t4_no_early_ack", acks, 0);
        check_eq("t4_still_busy", bus0.busy, 1);
        bus0.vsync = 1;
        step(1);
        check_eq("t4_sw_ack", bus0.sw_ack, 1);
        check_eq("t4_status", bus0.status, 0);
        check_eq("t4_applied", bus0.applied_count, 3);
        bus0.sw_req = 0;
        bus0.vsync = 0;

        // vsync timeout on the short-timeout instance: 1 + 1 + 1 + 32 + 200 cycles
        step(2);
        bus1.sw_box = {16'd60, 16'd60, 16'd1, 16'd1};
        bus1.sw_req = 1;
        cyc = 0;
        got = 0;
        while (cyc < 400 && !got) begin
            step(1);
            cyc++;
            if (bus1.sw_ack) got = 1;
        end
        check_eq("t5_ack_seen", got, 1);
        check_eq("t5_latency", cyc, 235);
        check_eq("t5_status", bus1.status, 2);
        check_eq("t5_applied", bus1.applied_count, 0);
        bus1.sw_req = 0;

        // Reset during BUSY aborts immediately, then a fresh request completes
        step(2);
        bus0.sw_box = {16'd160, 16'd150, 16'd60, 16'd50};
        bus0.sw_req = 1;
        step(10);
        check_eq("t6_busy_pre", bus0.busy, 1);
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_busy", bus0.busy, 0);
        check_eq("t6_rst_update", bus0.update, 0);
        check_eq("t6_rst_ack", bus0.sw_ack, 0);
        check_eq("t6_rst_status", bus0.status, 0);
        check_eq("t6_rst_applied", bus0.applied_count, 0);
        check_eq("t6_rst_last_src", bus0.last_src, 1);
        check_box0("t6_rst_box", 16'd10, 16'd10, 16'd100, 16'd100);
        step(1);
        bus0.sw_req = 0;
        step(1);
        check_eq("t6_held_ack", bus0.sw_ack, 0);
        resetn = 1'b1;
        step(1);
        bus0.sw_box = {16'd200, 16'd200, 16'd0, 16'd0};
        bus0.sw_req = 1;
        step(2);
        check_eq("t6_update", bus0.update, 1);
        check_box0("t6_box", 16'd0, 16'd0, 16'd200, 16'd200);
        step(40);
        bus0.vsync = 1;
        step(1);
        check_eq("t6_sw_ack", bus0.sw_ack, 1);
        check_eq("t6_status", bus0.status, 0);
        check_eq("t6_applied", bus0.applied_count, 1);
        bus0.sw_req = 0;
        bus0.vsync = 0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
